// File: rtl/seg7_mux_scan.sv
// Multiplexed 7-segment channel viewer: manual capture by select, or timed auto-scroll
// across NUM_CH channels, with a registered active-low segment drive.

module seg7_mux_scan_lane #(
    parameter int DATA_WIDTH = 4,
    parameter int SEL_W      = 3,
    parameter int LANE       = 0
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [SEL_W-1:0]      nxt,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sel_data,
    output logic [DATA_WIDTH-1:0] nxt_data
);
    localparam logic [SEL_W-1:0] ID = SEL_W'(LANE);

    // Each lane contributes its data only when addressed, so the top can OR-reduce.
    assign sel_data = (sel == ID) ? din : '0;
    assign nxt_data = (nxt == ID) ? din : '0;
endmodule

module seg7_mux_scan #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 5,
    parameter int SEL_W      = 3,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic [NUM_CH*DATA_WIDTH-1:0] Data,
    input  logic [SEL_W-1:0]             Sel,
    input  logic                         Mode,
    input  logic                         Load,
    input  logic                         Hold,
    output logic [6:0]                   Seg7,
    output logic [SEL_W-1:0]             ChIdx,
    output logic                         Valid
);
    localparam int               CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    typedef struct packed {
        logic                  en;
        logic [SEL_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] data;
    } cap_t;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] sel_lane, nxt_lane;
    logic [DATA_WIDTH-1:0]             sel_data, nxt_data, q;
    logic [SEL_W-1:0]                  nxt_idx;
    logic [CNT_W-1:0]                  cnt;
    logic                              man_load, man_ok, man_bad, wrap;
    cap_t                              cap;

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'h0: seg7_decode = 7'h40;
            4'h1: seg7_decode = 7'h79;
            4'h2: seg7_decode = 7'h24;
            4'h3: seg7_decode = 7'h30;
            4'h4: seg7_decode = 7'h19;
            4'h5: seg7_decode = 7'h12;
            4'h6: seg7_decode = 7'h02;
            4'h7: seg7_decode = 7'h78;
            4'h8: seg7_decode = 7'h00;
            4'h9: seg7_decode = 7'h10;
            4'hA: seg7_decode = 7'h08;
            4'hB: seg7_decode = 7'h03;
            4'hC: seg7_decode = 7'h46;
            4'hD: seg7_decode = 7'h21;
            4'hE: seg7_decode = 7'h06;
            default: seg7_decode = 7'h0E;
        endcase
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        seg7_mux_scan_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .SEL_W     (SEL_W),
            .LANE      (k)
        ) u_lane (
            .sel     (Sel),
            .nxt     (nxt_idx),
            .din     (Data[k*DATA_WIDTH +: DATA_WIDTH]),
            .sel_data(sel_lane[k]),
            .nxt_data(nxt_lane[k])
        );
    end

    always_comb begin
        sel_data = '0;
        nxt_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_data = sel_data | sel_lane[k];
            nxt_data = nxt_data | nxt_lane[k];
        end
    end

    assign man_load = !Mode && Load;
    assign man_ok   = man_load && ({1'b0, Sel} < NUM_CH_X);
    assign man_bad  = man_load && !man_ok;
    assign wrap     = Mode && !Hold && (cnt == CNT_LAST);
    assign nxt_idx  = (ChIdx == LAST_CH) ? '0 : ChIdx + 1'b1;

    always_comb begin
        cap = '0;
        if (man_ok) begin
            cap.en   = 1'b1;
            cap.idx  = Sel;
            cap.data = sel_data;
        end else if (wrap) begin
            cap.en   = 1'b1;
            cap.idx  = nxt_idx;
            cap.data = nxt_data;
        end
    end

    // Counter sits at zero throughout manual mode, so entering auto mode always
    // starts a full dwell from the current ChIdx.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            q     <= '0;
            ChIdx <= '0;
            cnt   <= '0;
            Valid <= 1'b0;
            Seg7  <= 7'h7F;
        end else begin
            if (!Mode)
                cnt <= '0;
            else if (!Hold)
                cnt <= wrap ? '0 : cnt + 1'b1;

            if (cap.en) begin
                q     <= cap.data;
                ChIdx <= cap.idx;
                Valid <= 1'b1;
            end

            if (man_bad || !Valid)
                Seg7 <= 7'h7F;
            else
                Seg7 <= seg7_decode(4'(q));
        end
    end
endmodule

// File: tb/tb_seg7_mux_scan.sv
// Bench for seg7_mux_scan: directed vector table, hand-written scroll/hold/reset
// sequences, and randomized traffic against a behavioural model.

module tb_seg7_mux_scan;
    localparam int DW  = 4;
    localparam int NCH = 5;
    localparam int SW  = 3;
    localparam int TD  = 4;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NCH*DW-1:0]   data = '0;
    logic [SW-1:0]       sel = '0;
    logic                mode = 1'b0, load = 1'b0, hold = 1'b0;
    logic [6:0]          seg7;
    logic [SW-1:0]       chidx;
    logic                valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [6:0] seg_tab [16];
    int         m_q, m_idx, m_elapsed;
    logic       m_valid;
    logic [6:0] m_seg;

    typedef struct {
        logic        rstn, mode, load, hold;
        logic [2:0]  sel;
        logic [19:0] data;
        logic [6:0]  seg;
        logic [2:0]  idx;
        logic        vld;
    } vec_t;

    vec_t vt [14];

    seg7_mux_scan #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .SEL_W     (SW),
        .TICK_DIV  (TD)
    ) dut (
        .Clock (clk),
        .Resetn(rstn),
        .Data  (data),
        .Sel   (sel),
        .Mode  (mode),
        .Load  (load),
        .Hold  (hold),
        .Seg7  (seg7),
        .ChIdx (chidx),
        .Valid (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int chan(input int k);
        logic [NCH*DW-1:0] d;
        d = data;
        return int'(d[k*DW +: DW]);
    endfunction

    // Model applies the rules on the inputs present at the rising edge.
    task automatic model_step();
        logic [6:0] seg_next;
        if (!rstn) begin
            m_q = 0; m_idx = 0; m_elapsed = 0; m_valid = 1'b0; m_seg = 7'h7F;
        end else begin
            if (!mode && load && int'(sel) >= NCH) seg_next = 7'h7F;
            else if (!m_valid)                     seg_next = 7'h7F;
            else                                   seg_next = seg_tab[m_q];
            if (!mode) begin
                m_elapsed = 0;
                if (load && int'(sel) < NCH) begin
                    m_idx = int'(sel); m_q = chan(m_idx); m_valid = 1'b1;
                end
            end else if (!hold) begin
                m_elapsed++;
                if (m_elapsed == TD) begin
                    m_elapsed = 0;
                    m_idx = (m_idx + 1) % NCH;
                    m_q = chan(m_idx);
                    m_valid = 1'b1;
                end
            end
            m_seg = seg_next;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [6:0] scroll_seg [5];
        bit found;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        scroll_seg = '{7'h24, 7'h30, 7'h19, 7'h12, 7'h79};

        //          rstn mode load hold sel   data       seg    idx  vld
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'h97531, 7'h7F, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 20'h97531, 7'h7F, 3'd0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 20'h97531, 7'h7F, 3'd2, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 20'h97531, 7'h12, 3'd2, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 20'h97531, 7'h7F, 3'd2, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 20'h97531, 7'h12, 3'd2, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 20'h97F31, 7'h12, 3'd2, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 20'h97F31, 7'h12, 3'd4, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 20'h97F31, 7'h10, 3'd4, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 20'h97F38, 7'h10, 3'd0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 20'h97F38, 7'h00, 3'd0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 20'h97F38, 7'h7F, 3'd0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 20'h97F38, 7'h7F, 3'd0, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 20'h97F38, 7'h7F, 3'd0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            rstn = vt[i].rstn; mode = vt[i].mode; load = vt[i].load;
            hold = vt[i].hold; sel = vt[i].sel; data = vt[i].data;
            tick();
            chk($sformatf("vec%0d seg7", i),  32'(seg7),  32'(vt[i].seg));
            chk($sformatf("vec%0d chidx", i), 32'(chidx), 32'(vt[i].idx));
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vt[i].vld));
        end

        // Auto-scroll from reset with Load held high (must be ignored).
        rstn = 1'b0; mode = 1'b0; load = 1'b0; hold = 1'b0; sel = 3'd0;
        tick();
        rstn = 1'b1; mode = 1'b1; load = 1'b1; sel = 3'd3; data = 20'h54321;
        for (int n = 1; n <= 21; n++) begin
            tick();
            chk($sformatf("scroll%0d chidx", n), 32'(chidx), 32'((n / TD) % NCH));
            chk($sformatf("scroll%0d valid", n), 32'(valid), 32'(n >= TD));
            if (n <= TD)
                chk($sformatf("scroll%0d seg7 blank", n), 32'(seg7), 32'h7F);
            else if (n % TD == 1)
                chk($sformatf("scroll%0d seg7", n), 32'(seg7), 32'(scroll_seg[n / TD - 1]));
        end

        // Hold mid-dwell: one dwell cycle already spent, three remain on release.
        load = 1'b0; hold = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("hold%0d chidx", n), 32'(chidx), 32'd0);
            chk($sformatf("hold%0d seg7", n),  32'(seg7),  32'h79);
        end
        hold = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk($sformatf("release%0d chidx", n), 32'(chidx), 32'(n >= 3 ? 1 : 0));
        end
        chk("release seg7", 32'(seg7), 32'h24);

        // Scroll on to channel 3, then reset mid-dwell with a Load present.
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (chidx == 3'd3) found = 1'b1;
        end
        chk("reach ch3", 32'(found), 32'd1);
        tick();
        rstn = 1'b0; mode = 1'b0; load = 1'b1; sel = 3'd2;
        tick();
        chk("rst chidx", 32'(chidx), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst seg7",  32'(seg7),  32'h7F);
        rstn = 1'b1; mode = 1'b1; load = 1'b0;
        for (int n = 1; n <= TD; n++) begin
            tick();
            chk($sformatf("post_rst%0d chidx", n), 32'(chidx), 32'(n == TD ? 1 : 0));
            chk($sformatf("post_rst%0d seg7", n),  32'(seg7),  32'h7F);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rstn = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            load = ($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 3) == 0);
            sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) data = 20'($urandom);
            tick();
            chk($sformatf("rand%0d seg7", n),  32'(seg7),  32'(m_seg));
            chk($sformatf("rand%0d chidx", n), 32'(chidx), 32'(m_idx));
            chk($sformatf("rand%0d valid", n), 32'(valid), 32'(m_valid));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_mux_scan.md
SEG7_MUX_SCAN -- requirements
Module: seg7_mux_scan

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL be the per-channel data width (legal range 1..4).
REQ-002 Parameter NUM_CH, default 5, SHALL be the number of input channels (legal range 2..16).
REQ-003 Parameter SEL_W, default 3, SHALL be the select width, with 2**SEL_W >= NUM_CH.
REQ-004 Parameter TICK_DIV, default 50000000, SHALL be the auto-scroll dwell in clocks (minimum 2).
REQ-005 Port Clock, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port Resetn, input, 1, SHALL be the synchronous, active-low reset.
REQ-007 Port Data, input, NUM_CH*DATA_WIDTH, SHALL carry the flattened channels; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port Sel, input, SEL_W, SHALL be the manual channel select.
REQ-009 Port Mode, input, 1: 0 = manual, 1 = auto-scroll.
REQ-010 Port Load, input, 1, SHALL be the manual capture strobe (level-sampled every cycle).
REQ-011 Port Hold, input, 1, SHALL freeze auto-scroll.
REQ-012 Port Seg7, output, 7, SHALL be the registered segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-013 Port ChIdx, output, SEL_W, SHALL be the registered index of the channel currently displayed.
REQ-014 Port Valid, output, 1, SHALL be high once any capture has occurred since reset.

Function
REQ-015 The block SHALL hold an internal capture register Q, DATA_WIDTH bits wide and zero-extended to 4 bits for decoding.
REQ-016 Manual capture: in a cycle with Mode=0, Load=1 and Sel<NUM_CH, the block SHALL set Q<=channel Sel, ChIdx<=Sel and Valid<=1.
REQ-017 In a cycle with Mode=0, Load=1 and Sel>=NUM_CH, Q, ChIdx and Valid SHALL remain unchanged.
REQ-018 Manual-mode blanking: in that same cycle, Seg7 SHALL load 7'h7F (blank).
REQ-019 Auto-scroll counter: with Mode=1 and Hold=0, a tick counter SHALL count 0..TICK_DIV-1 and then wrap to 0.
REQ-020 Auto-scroll advance: in the cycle the counter wraps, ChIdx SHALL advance by one, wrapping from NUM_CH-1 to 0.
REQ-021 Auto-scroll capture: in that same cycle, Q SHALL load the new channel's data and Valid<=1.
REQ-022 Hold: with Mode=1 and Hold=1, the counter, ChIdx and Q SHALL all freeze.
REQ-023 Mode switch: on a 0->1 transition of Mode, the counter SHALL clear to 0 and scrolling SHALL resume from the current ChIdx.
REQ-024 Load SHALL be ignored while Mode=1.
REQ-025 Display latency: Seg7 SHALL be registered from Q, giving a Load-to-Seg7 latency of 2 cycles; ChIdx SHALL update 1 cycle after the capture edge.
REQ-026 Decode table (hex digit -> Seg7): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
REQ-027 While Valid=0, Seg7 SHALL be 7'h7F regardless of Q.
REQ-028 Data changes on a non-selected channel, or on the selected channel without a capture event, SHALL NOT alter Q or Seg7.

Reset
REQ-029 While Resetn=0 at a rising Clock edge, the block SHALL set Q=0, ChIdx=0, tick counter=0, Valid=0 and Seg7=7'h7F.
REQ-030 Reset SHALL take priority over Load, Mode and Hold in the same cycle.
REQ-031 A reset asserted mid-dwell SHALL abandon the dwell; after release, the first auto advance SHALL occur TICK_DIV cycles later.

Verification
REQ-032 Reset then Mode=0, Sel=2, ch2=4'h5, Load pulse -> ChIdx=2 after 1 cycle; Seg7=7'h12 after 2 cycles; Valid=1.
REQ-033 Mode=0, Sel=7, Load pulse with NUM_CH=5 -> Seg7=7'h7F; ChIdx and Q unchanged.
REQ-034 TICK_DIV=4, Mode=1 from ChIdx=0, channels 0..4 = 1,2,3,4,5 -> ChIdx steps 1,2,3,4,0 every 4 cycles; Seg7 follows 24, 30, 19, 12, 79.
REQ-035 Auto mode with Hold=1 for 10 cycles mid-dwell -> ChIdx and Seg7 frozen; on release the remaining dwell completes.
REQ-036 Resetn=0 asserted during auto scroll at ChIdx=3 -> next cycle ChIdx=0, Valid=0, Seg7=7'h7F; Load in the reset cycle is ignored.
REQ-037 Mode=1 with Load=1 asserted -> no capture outside tick boundaries.
